// File: rtl/multi_onepulser.sv
// Multi-channel synchronise/debounce/one-pulse for push-buttons.
// Define ONEPULSER_AUTO_REPEAT_EN to add hold-to-repeat pulses.
module multi_onepulser #(
  parameter int CH       = 4,
  parameter int DEBOUNCE = 4,
  parameter int HOLD     = 8,
  parameter int REPEAT   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] btn,
  output logic [CH-1:0] pulse,
  output logic [CH-1:0] level,
  output logic          any_pulse
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    HELD = 2'd2
  } state_t;

  if (CH < 1 || DEBOUNCE < 1 || HOLD < 2 || REPEAT < 2) begin : g_bad_cfg
    $error("multi_onepulser: illegal parameter set");
  end

  logic [CH-1:0] s1_q, s1_d;
  logic [CH-1:0] s2_q, s2_d;
  logic [CH-1:0] db_q, db_d;
  logic [CW-1:0] cnt_q [CH];
  logic [CW-1:0] cnt_d [CH];
  state_t        st_q  [CH];
  state_t        st_d  [CH];

`ifdef ONEPULSER_AUTO_REPEAT_EN
  localparam int MAXHR = (HOLD > REPEAT) ? HOLD : REPEAT;
  localparam int RW    = $clog2(MAXHR + 1);

  logic [RW-1:0] rpt_q [CH];
  logic [RW-1:0] rpt_d [CH];
  logic [CH-1:0] again_q, again_d;
  logic [RW-1:0] thr;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
      db_q <= '0;
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= '0;
        st_q[i]  <= IDLE;
      end
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      db_q <= db_d;
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        st_q[i]  <= st_d[i];
      end
    end
  end

`ifdef ONEPULSER_AUTO_REPEAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      again_q <= '0;
      for (int i = 0; i < CH; i++) begin
        rpt_q[i] <= '0;
      end
    end else begin
      again_q <= again_d;
      for (int i = 0; i < CH; i++) begin
        rpt_q[i] <= rpt_d[i];
      end
    end
  end
`endif

  always_comb begin
    s1_d = btn;
    s2_d = s1_q;
    db_d = db_q;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = '0;
      // any return to the current level restarts the count
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE - 1)) begin
          db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
`ifdef ONEPULSER_AUTO_REPEAT_EN
    again_d = again_q;
    thr     = '0;
`endif
    for (int i = 0; i < CH; i++) begin
      st_d[i] = st_q[i];
`ifdef ONEPULSER_AUTO_REPEAT_EN
      rpt_d[i] = rpt_q[i];
      thr = again_q[i] ? RW'(REPEAT - 1)
                       : RW'(HOLD - 1);
`endif
      unique case (1'b1)
        (st_q[i] == IDLE): begin
          if (db_q[i]) begin
            st_d[i] = FIRE;
`ifdef ONEPULSER_AUTO_REPEAT_EN
            rpt_d[i]   = '0;
            again_d[i] = 1'b0;
`endif
          end
        end
        (st_q[i] == FIRE): begin
          st_d[i] = HELD;
`ifdef ONEPULSER_AUTO_REPEAT_EN
          rpt_d[i] = rpt_q[i] + 1'b1;
`endif
        end
        (st_q[i] == HELD): begin
          if (!db_q[i]) begin
            st_d[i] = IDLE;
`ifdef ONEPULSER_AUTO_REPEAT_EN
            rpt_d[i]   = '0;
            again_d[i] = 1'b0;
          end else if (rpt_q[i] == thr) begin
            st_d[i]    = FIRE;
            rpt_d[i]   = '0;
            again_d[i] = 1'b1;
          end else begin
            rpt_d[i] = rpt_q[i] + 1'b1;
`endif
          end
        end
        default: begin
          st_d[i] = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      pulse[i] = (st_q[i] == FIRE);
    end
  end

  assign level     = db_q;
  assign any_pulse = |pulse;

endmodule

// File: tb/tb_multi_onepulser.sv
// Directed bench for multi_onepulser with a pulse scoreboard.
module tb_multi_onepulser;

  localparam int CH   = 4;
  localparam int DB   = 4;
  localparam int HOLD = 8;
  localparam int REP  = 4;

  typedef struct {
    int            c;
    logic [CH-1:0] m;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CH-1:0] btn = '0;
  logic [CH-1:0] pulse;
  logic [CH-1:0] level;
  logic          any_pulse;

  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;
  ev_t q[$];

  multi_onepulser #(
    .CH      (CH),
    .DEBOUNCE(DB),
    .HOLD    (HOLD),
    .REPEAT  (REP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .pulse    (pulse),
    .level    (level),
    .any_pulse(any_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_pulse(input int c,
                              input logic [CH-1:0] m);
    ev_t e;
    e.c = c;
    e.m = m;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
             tag, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [CH-1:0] em;
    em = '0;
    while (q.size() > 0 && q[0].c <= cyc) begin
      em |= q[0].m;
      void'(q.pop_front());
    end
    if (pulse !== '0 || em != '0) begin
      total++;
      assert (pulse === em) else begin
        bad++;
        $error("FAIL pulse cyc=%0d observed=%b expected=%b",
               cyc, pulse, em);
      end
      total++;
      assert (any_pulse === (|em)) else begin
        bad++;
        $error("FAIL any_pulse cyc=%0d observed=%b expected=%b",
               cyc, any_pulse, |em);
      end
    end
  end

  initial begin
    int c;
    int t;
    int rel;
    int f;

    #1;
    chk("rst_pulse", 32'(pulse), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_any", 32'(any_pulse), 32'd0);
    btn = 4'b1111;
    tick(3);
    chk("rst_hold_level", 32'(level), 32'd0);
    btn = '0;
    tick(2);
    rst = 1'b1;
    tick(3);

    // single press on channel 0
    c = cyc;
    btn[0] = 1'b1;
    expect_pulse(c + DB + 3, 4'b0001);
    tick(DB + 1);
    chk("lvl0_pre", 32'(level), 32'd0);
    tick(1);
    chk("lvl0_rise", 32'(level), 32'b0001);
    tick(10);
    c = cyc;
    btn[0] = 1'b0;
    tick(DB + 1);
    chk("lvl0_still", 32'(level), 32'b0001);
    tick(1);
    chk("lvl0_fall", 32'(level), 32'd0);
    tick(4);

    // bouncing press on channel 1
    c = cyc;
    btn[1] = 1'b1;
    tick(3);
    btn[1] = 1'b0;
    tick(1);
    btn[1] = 1'b1;
    expect_pulse(c + 4 + DB + 3, 4'b0010);
    tick(3);
    chk("bounce_mid", 32'(level), 32'd0);
    tick(DB - 2);
    chk("bounce_pre", 32'(level), 32'd0);
    tick(1);
    chk("bounce_rise", 32'(level), 32'b0010);
    tick(10);

    // asynchronous reset while channel 1 is held
    #2;
    rst = 1'b0;
    #1;
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_pulse", 32'(pulse), 32'd0);
    chk("arst_any", 32'(any_pulse), 32'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    c = cyc;
    expect_pulse(c + DB + 3, 4'b0010);
    tick(DB + 2);
    chk("arst_relevel", 32'(level), 32'b0010);
    tick(6);
    btn[1] = 1'b0;
    tick(DB + 6);
    chk("ch1_released", 32'(level), 32'd0);

    // simultaneous press on channels 0 and 3
    c = cyc;
    btn = 4'b1001;
    expect_pulse(c + DB + 3, 4'b1001);
    tick(DB + 2);
    chk("sim_level", 32'(level), 32'b1001);
    tick(6);
    btn = '0;
    tick(DB + 6);

    // long hold on channel 2
    c = cyc;
    btn[2] = 1'b1;
    t = c + DB + 3;
    rel = t + 25;
    f = rel + DB + 2;
    expect_pulse(t, 4'b0100);
`ifdef ONEPULSER_AUTO_REPEAT_EN
    for (int p = t + HOLD; p <= f; p += REP) begin
      expect_pulse(p, 4'b0100);
    end
`endif
    tick(rel - c);
    chk("hold_level", 32'(level), 32'b0100);
    btn[2] = 1'b0;
    tick(DB + 15);
    chk("hold_release", 32'(level), 32'd0);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
